// File: rtl/cp0_nested_if.sv
// Bus between the pipeline and the CP0 block: mtc0/mfc0 access, trap inputs,
// and the trap/EPC outputs. Scalar clock and reset stay outside the bundle.
interface cp0_nested_if #(
    parameter int HW_INT_N = 5
) ();
    logic [4:0]          number;
    logic                write_enable;
    logic [31:0]         write_data;
    logic [31:0]         VPC;
    logic                BDIn;
    logic [4:0]          ExcCodeIn;
    logic [HW_INT_N-1:0] HWInt;
    logic                EXLClr;
    logic [31:0]         read_data;
    logic [31:0]         EPCOut;
    logic                Request;
    logic                TimerInt;

    modport master (
        output number, write_enable, write_data, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  read_data, EPCOut, Request, TimerInt
    );

    modport slave (
        input  number, write_enable, write_data, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output read_data, EPCOut, Request, TimerInt
    );
endinterface

// File: rtl/cp0_nested.sv
// MIPS-style CP0 with a small EPC stack for nested traps plus a Count/Compare
// timer. Interrupts are only taken at level 0; exceptions nest up to NEST_DEPTH.
module cp0_nested #(
    parameter int HW_INT_N   = 5,
    parameter int NEST_DEPTH = 2,
    parameter int TIMER_EN   = 1
) (
    input logic         clk,
    input logic         reset,
    cp0_nested_if.slave bus
);
    localparam int               LVL_W   = $clog2(NEST_DEPTH + 1);
    localparam int               STK_N   = 1 << LVL_W;
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NEST_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
    localparam logic [31:0]      PRID    = 32'h0043_5030;

    localparam logic [4:0] R_COUNT   = 5'd9;
    localparam logic [4:0] R_COMPARE = 5'd11;
    localparam logic [4:0] R_SR      = 5'd12;
    localparam logic [4:0] R_CAUSE   = 5'd13;
    localparam logic [4:0] R_EPC     = 5'd14;
    localparam logic [4:0] R_PRID    = 5'd15;

    logic [31:0]      sr_q;
    logic             cause_bd;
    logic [4:0]       cause_exc;
    logic [4:0]       ip_hw_q;
    logic             timer_pend;
    logic [31:0]      count_q;
    logic [31:0]      compare_q;
    logic [LVL_W-1:0] lvl_q;
    // Stack is sized to a power of two so lvl_q indexes it without width games;
    // entries at and above NEST_DEPTH are never written by a trap.
    logic [31:0]      stack [STK_N];

    logic [4:0]       hw_pad;
    logic [5:0]       ip_live;
    logic [LVL_W-1:0] top;
    logic [31:0]      epc_top;
    logic             exl;
    logic             int_ok;
    logic             exc_ok;
    logic             trap;
    logic             wr_ok;
    logic             cmp_wr;
    logic [31:0]      cause_rd;

    always_comb begin
        hw_pad                 = '0;
        hw_pad[HW_INT_N-1:0]   = bus.HWInt;
    end

    assign ip_live  = {timer_pend, hw_pad};
    assign exl      = (lvl_q != '0);
    assign top      = exl ? (lvl_q - LVL_ONE) : '0;
    assign epc_top  = stack[top];

    assign int_ok   = sr_q[0] & ~exl & (|(sr_q[15:10] & ip_live));
    assign exc_ok   = (bus.ExcCodeIn != 5'd0) & (lvl_q < LVL_MAX);
    assign trap     = ~bus.EXLClr & (int_ok | exc_ok);
    assign wr_ok    = bus.write_enable & ~bus.EXLClr & ~trap;
    assign cmp_wr   = wr_ok & (bus.number == R_COMPARE);

    assign cause_rd = {cause_bd, 15'd0, timer_pend, ip_hw_q, 3'd0, cause_exc, 2'd0};

    assign bus.Request  = trap;
    assign bus.TimerInt = timer_pend;

    // EPC writes are forwarded so an eret issued right after mtc0 EPC sees the new value.
    assign bus.EPCOut = (~trap & bus.write_enable & (bus.number == R_EPC)) ?
                        bus.write_data : epc_top;

    always_comb begin
        bus.read_data = 32'd0;
        case (bus.number)
            R_COUNT:   bus.read_data = count_q;
            R_COMPARE: bus.read_data = compare_q;
            R_SR:      bus.read_data = {sr_q[31:2], exl, sr_q[0]};
            R_CAUSE:   bus.read_data = cause_rd;
            R_EPC:     bus.read_data = epc_top;
            R_PRID:    bus.read_data = PRID;
            default:   bus.read_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q       <= 32'd0;
            cause_bd   <= 1'b0;
            cause_exc  <= 5'd0;
            ip_hw_q    <= 5'd0;
            timer_pend <= 1'b0;
            count_q    <= 32'd0;
            compare_q  <= 32'hFFFF_FFFF;
            lvl_q      <= '0;
            for (int i = 0; i < STK_N; i++) begin
                stack[i] <= 32'd0;
            end
        end else begin
            ip_hw_q <= hw_pad;
            count_q <= count_q + 32'd1;

            // Clearing by a Compare write wins over a match in the same cycle.
            if (TIMER_EN == 0) begin
                timer_pend <= 1'b0;
            end else if (cmp_wr) begin
                timer_pend <= 1'b0;
            end else if (count_q == compare_q) begin
                timer_pend <= 1'b1;
            end

            if (bus.EXLClr) begin
                if (exl) begin
                    lvl_q <= lvl_q - LVL_ONE;
                end
            end else if (trap) begin
                stack[lvl_q] <= bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
                cause_bd     <= bus.BDIn;
                cause_exc    <= int_ok ? 5'd0 : bus.ExcCodeIn;
                lvl_q        <= lvl_q + LVL_ONE;
            end else if (bus.write_enable) begin
                case (bus.number)
                    R_COUNT:   count_q   <= bus.write_data;
                    R_COMPARE: compare_q <= bus.write_data;
                    R_SR:      sr_q      <= bus.write_data & ~32'h0000_0002;
                    R_EPC:     stack[top] <= bus.write_data;
                    default:   ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cp0_nested.sv
// Scoreboard bench for cp0_nested: expectations are queued with the stimulus
// and drained against the DUT once it has produced the corresponding output.
module tb_cp0_nested;
    localparam int SEL_REQ  = 32;
    localparam int SEL_EPCO = 33;
    localparam int SEL_TINT = 34;
    localparam logic [31:0] PRID = 32'h0043_5030;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    cp0_nested_if #(.HW_INT_N(5)) bus ();

    cp0_nested #(
        .HW_INT_N  (5),
        .NEST_DEPTH(2),
        .TIMER_EN  (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.number       = 5'd0;
        bus.write_enable = 1'b0;
        bus.write_data   = 32'd0;
        bus.VPC          = 32'd0;
        bus.BDIn         = 1'b0;
        bus.ExcCodeIn    = 5'd0;
        bus.HWInt        = 5'd0;
        bus.EXLClr       = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] num, input logic [31:0] data);
        bus.number       = num;
        bus.write_data   = data;
        bus.write_enable = 1'b1;
        tick();
        bus.write_enable = 1'b0;
        bus.write_data   = 32'd0;
    endtask

    task automatic push(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic observe(input int sel, output logic [31:0] obs);
        if (sel < 32) bus.number = 5'(sel);
        #1;
        case (sel)
            SEL_REQ:  obs = {31'd0, bus.Request};
            SEL_EPCO: obs = bus.EPCOut;
            SEL_TINT: obs = {31'd0, bus.TimerInt};
            default:  obs = bus.read_data;
        endcase
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] obs;
        push("rst_sr", 12, 32'd0);
        push("rst_cause", 13, 32'd0);
        push("rst_epc", 14, 32'd0);
        push("rst_request", SEL_REQ, 32'd0);
        push("rst_timerint", SEL_TINT, 32'd0);
        push("rst_epcout", SEL_EPCO, 32'd0);
        push("rst_compare", 11, 32'hFFFF_FFFF);
        push("rst_count", 9, 32'd0);
        push("rst_prid", 15, PRID);
        push("rst_unmapped", 5, 32'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_interrupt();
        exp_t e;
        logic [31:0] obs;
        mtc0(5'd12, 32'h0000_0401);
        bus.HWInt = 5'b00001;
        bus.VPC   = 32'h0000_1000;
        push("int_request", SEL_REQ, 32'd1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
        tick();
        idle();
        push("int_cause", 13, 32'h0000_0400);
        push("int_epc", 14, 32'h0000_1000);
        push("int_sr", 12, 32'h0000_0403);
        push("int_request_off", SEL_REQ, 32'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
    endtask

    task automatic test_nested();
        exp_t e;
        logic [31:0] obs;
        bus.ExcCodeIn = 5'd12;
        bus.VPC       = 32'h0000_3008;
        bus.BDIn      = 1'b1;
        push("nest_request", SEL_REQ, 32'd1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
        tick();
        idle();
        push("nest_epc", 14, 32'h0000_3004);
        push("nest_epcout", SEL_EPCO, 32'h0000_3004);
        push("nest_cause", 13, 32'h8000_0030);
        push("nest_sr", 12, 32'h0000_0403);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
    endtask

    task automatic test_depth_limit();
        exp_t e;
        logic [31:0] obs;
        bus.ExcCodeIn = 5'd10;
        bus.VPC       = 32'h0000_5000;
        push("full_request", SEL_REQ, 32'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
        tick();
        idle();
        push("full_epc", 14, 32'h0000_3004);
        push("full_cause", 13, 32'h8000_0030);
        push("full_sr", 12, 32'h0000_0403);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
        bus.EXLClr = 1'b1;
        tick();
        idle();
        push("pop_epc", 14, 32'h0000_1000);
        push("pop_epcout", SEL_EPCO, 32'h0000_1000);
        push("pop_sr", 12, 32'h0000_0403);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
    endtask

    task automatic test_eret_vs_exc();
        exp_t e;
        logic [31:0] obs;
        bus.EXLClr    = 1'b1;
        bus.ExcCodeIn = 5'd4;
        bus.VPC       = 32'h0000_6000;
        push("eret_request", SEL_REQ, 32'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
        tick();
        idle();
        push("eret_sr", 12, 32'h0000_0401);
        push("eret_epc", 14, 32'h0000_1000);
        push("eret_cause", 13, 32'h8000_0030);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
        bus.EXLClr = 1'b1;
        tick();
        idle();
        push("eret_lvl0_sr", 12, 32'h0000_0401);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        logic [31:0] obs;
        mtc0(5'd12, 32'h0000_0C01);
        bus.HWInt        = 5'b00010;
        bus.ExcCodeIn    = 5'd7;
        bus.VPC          = 32'h0000_2000;
        bus.BDIn         = 1'b1;
        bus.write_enable = 1'b1;
        bus.number       = 5'd14;
        bus.write_data   = 32'hDEAD_BEEF;
        push("prio_request", SEL_REQ, 32'd1);
        push("prio_epcout", SEL_EPCO, 32'h0000_1000);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
        tick();
        idle();
        push("prio_cause", 13, 32'h8000_0800);
        push("prio_epc", 14, 32'h0000_1FFC);
        push("prio_sr", 12, 32'h0000_0C03);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
        bus.EXLClr = 1'b1;
        tick();
        idle();
        push("prio_ret_sr", 12, 32'h0000_0C01);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
    endtask

    task automatic test_mtc0();
        exp_t e;
        logic [31:0] obs;
        bus.write_enable = 1'b1;
        bus.number       = 5'd14;
        bus.write_data   = 32'hABCD_0000;
        push("fwd_epcout", SEL_EPCO, 32'hABCD_0000);
        push("fwd_no_rdfwd", 14, 32'h0000_1FFC);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
        tick();
        idle();
        mtc0(5'd12, 32'h0000_0403);
        mtc0(5'd13, 32'hFFFF_FFFF);
        mtc0(5'd15, 32'd0);
        push("wr_epc", 14, 32'hABCD_0000);
        push("wr_sr_exl_masked", 12, 32'h0000_0401);
        push("wr_cause_ignored", 13, 32'h8000_0000);
        push("wr_prid_ignored", 15, PRID);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
        bus.EXLClr       = 1'b1;
        bus.write_enable = 1'b1;
        bus.number       = 5'd12;
        bus.write_data   = 32'd0;
        tick();
        idle();
        push("eret_drops_wr", 12, 32'h0000_0401);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
    endtask

    task automatic test_timer();
        exp_t e;
        logic [31:0] obs;
        int n;
        mtc0(5'd9, 32'd15);
        mtc0(5'd11, 32'd20);
        bus.VPC = 32'h0000_7000;
        mtc0(5'd12, 32'h0000_8001);
        n = 0;
        while (bus.TimerInt !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL timer_latency: got %0d cycles expected 4", n); end
        push("timer_count", 9, 32'd21);
        push("timer_request", SEL_REQ, 32'd1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
        tick();
        bus.VPC = 32'd0;
        push("timer_req_pulse", SEL_REQ, 32'd0);
        push("timer_sticky", SEL_TINT, 32'd1);
        push("timer_cause", 13, 32'h0000_8000);
        push("timer_epc", 14, 32'h0000_7000);
        push("timer_sr", 12, 32'h0000_8003);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
        mtc0(5'd11, 32'hFFFF_FFFF);
        push("timer_clr", SEL_TINT, 32'd0);
        push("timer_clr_cause", 13, 32'h0000_0000);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
        bus.EXLClr = 1'b1;
        tick();
        idle();
        push("timer_ret_sr", 12, 32'h0000_8001);
        push("timer_ret_req", SEL_REQ, 32'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
    endtask

    task automatic test_reset_trap();
        exp_t e;
        logic [31:0] obs;
        mtc0(5'd12, 32'h0000_0401);
        bus.HWInt = 5'b00001;
        bus.VPC   = 32'h0000_9000;
        reset     = 1'b0;
        tick();
        idle();
        push("rt_sr", 12, 32'd0);
        push("rt_cause", 13, 32'd0);
        push("rt_epc", 14, 32'd0);
        push("rt_count", 9, 32'd0);
        push("rt_compare", 11, 32'hFFFF_FFFF);
        push("rt_epcout", SEL_EPCO, 32'd0);
        push("rt_request", SEL_REQ, 32'd0);
        push("rt_timerint", SEL_TINT, 32'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
        reset = 1'b1;
        tick();
        push("rt_after_epc", 14, 32'd0);
        push("rt_after_sr", 12, 32'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            observe(e.sel, obs);
            checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        end
    endtask

    initial begin
        idle();
        reset = 1'b0;
        repeat (3) tick();
        test_reset();
        test_interrupt();
        test_nested();
        test_depth_limit();
        test_eret_vs_exc();
        test_priority();
        test_mtc0();
        test_timer();
        test_reset_trap();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
